// File: rtl/multdiv_issue_ctrl.sv
// Execute-stage sequencer for the multdiv unit: registers operands, pulses the start strobe,
// stalls the pipeline while the op runs, and returns the result as a one-cycle writeback.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for req_valid; stall follows req_valid
// ISSUE  | one-cycle md_ctrl_mult / md_ctrl_div start pulse
// BUSY   | waiting for md_ready (ignored at cnt 0) or the watchdog limit
// WB     | one-cycle wb_valid with latched result; stall released
module multdiv_issue_ctrl #(
   parameter int WIDTH      = 32,
   parameter int TAG_W      = 5,
   parameter int MAX_CYCLES = 40
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   input  logic             req_is_div,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [TAG_W-1:0] req_rd,
   input  logic             flush,
   output logic             stall,
   output logic [WIDTH-1:0] md_operandA,
   output logic [WIDTH-1:0] md_operandB,
   output logic             md_ctrl_mult,
   output logic             md_ctrl_div,
   input  logic [WIDTH-1:0] md_result,
   input  logic             md_except,
   input  logic             md_ready,
   output logic             wb_valid,
   output logic [TAG_W-1:0] wb_rd,
   output logic [WIDTH-1:0] wb_data,
   output logic             wb_except,
   output logic             timeout
);

   localparam int CNT_W = $clog2(MAX_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_BUSY  = 2'd2,
      S_WB    = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;
   logic             done_ready;
   logic             done_timeout;

   logic             ctrl_mult_q;
   logic             ctrl_div_q;
   logic             wb_valid_q;
   logic             timeout_q;
   logic [TAG_W-1:0] rd_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      accept       = 1'b0;
      done_ready   = 1'b0;
      done_timeout = 1'b0;
      stall        = 1'b0;
      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               stall = req_valid;
               if (req_valid) begin
                  accept  = 1'b1;
                  state_d = S_ISSUE;
               end
            end
            S_ISSUE: begin
               stall   = 1'b1;
               cnt_d   = '0;
               state_d = S_BUSY;
            end
            S_BUSY: begin
               stall = 1'b1;
               cnt_d = cnt_q + CNT_W'(1);
               // A ready seen at cnt 0 may belong to the previous op, so it is never taken.
               if (md_ready && (cnt_q != '0)) begin
                  done_ready = 1'b1;
                  state_d    = S_WB;
               end else if (cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
                  done_timeout = 1'b1;
                  state_d      = S_WB;
               end
            end
            S_WB: begin
               // req_valid still shows the retiring op here, so it is not looked at.
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ctrl_mult_q <= 1'b0;
         ctrl_div_q  <= 1'b0;
         wb_valid_q  <= 1'b0;
         timeout_q   <= 1'b0;
         rd_q        <= '0;
         md_operandA <= '0;
         md_operandB <= '0;
         wb_rd       <= '0;
         wb_data     <= '0;
         wb_except   <= 1'b0;
      end else begin
         ctrl_mult_q <= accept & ~req_is_div;
         ctrl_div_q  <= accept & req_is_div;
         wb_valid_q  <= done_ready | done_timeout;
         timeout_q   <= done_timeout;
         if (accept) begin
            md_operandA <= req_a;
            md_operandB <= req_b;
            rd_q        <= req_rd;
         end
         if (done_ready) begin
            wb_rd     <= rd_q;
            wb_data   <= md_result;
            wb_except <= md_except;
         end else if (done_timeout) begin
            wb_rd     <= rd_q;
            wb_data   <= '0;
            wb_except <= 1'b1;
         end
      end
   end

   // A flush in the pulse or writeback cycle suppresses the strobe in that same cycle.
   assign md_ctrl_mult = ctrl_mult_q & ~flush;
   assign md_ctrl_div  = ctrl_div_q & ~flush;
   assign wb_valid     = wb_valid_q & ~flush;
   assign timeout      = timeout_q & ~flush;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Bench for multdiv_issue_ctrl: behavioural multdiv model plus a writeback scoreboard.
module tb_multdiv_issue_ctrl;

   localparam int WIDTH      = 32;
   localparam int TAG_W      = 5;
   localparam int MAX_CYCLES = 40;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_is_div = 1'b0;
   logic [WIDTH-1:0] req_a = '0;
   logic [WIDTH-1:0] req_b = '0;
   logic [TAG_W-1:0] req_rd = '0;
   logic             flush = 1'b0;
   logic             stall;
   logic [WIDTH-1:0] md_operandA;
   logic [WIDTH-1:0] md_operandB;
   logic             md_ctrl_mult;
   logic             md_ctrl_div;
   logic [WIDTH-1:0] md_result = '0;
   logic             md_except = 1'b0;
   logic             md_ready = 1'b0;
   logic             wb_valid;
   logic [TAG_W-1:0] wb_rd;
   logic [WIDTH-1:0] wb_data;
   logic             wb_except;
   logic             timeout;

   multdiv_issue_ctrl #(
      .WIDTH     (WIDTH),
      .TAG_W     (TAG_W),
      .MAX_CYCLES(MAX_CYCLES)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_is_div  (req_is_div),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_rd      (req_rd),
      .flush       (flush),
      .stall       (stall),
      .md_operandA (md_operandA),
      .md_operandB (md_operandB),
      .md_ctrl_mult(md_ctrl_mult),
      .md_ctrl_div (md_ctrl_div),
      .md_result   (md_result),
      .md_except   (md_except),
      .md_ready    (md_ready),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .wb_except   (wb_except),
      .timeout     (timeout)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [TAG_W-1:0] rd;
      logic [WIDTH-1:0] data;
      logic             exc;
      logic             to;
   } exp_t;

   exp_t sb[$];
   exp_t e_mon;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int pulse_cnt = 0;
   int pulse_cyc = 0;
   int wb_cyc = 0;
   logic pulse_div = 1'b0;

   int   m_lat = 5;
   int   m_cd = 0;
   bit   m_never = 1'b0;
   bit   m_sticky = 1'b0;
   logic [WIDTH-1:0] m_res = '0;
   logic             m_exc = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   always @(posedge clock) cyc++;

   // multdiv model: result appears m_lat cycles after the start pulse
   always @(posedge clock) begin
      #1;
      if (md_ctrl_mult || md_ctrl_div) begin
         m_cd = m_lat;
         if (md_ctrl_div) begin
            if (md_operandB == '0) begin
               m_res = '0;
               m_exc = 1'b1;
            end else begin
               m_res = $signed(md_operandA) / $signed(md_operandB);
               m_exc = 1'b0;
            end
         end else begin
            m_res = $signed(md_operandA) * $signed(md_operandB);
            m_exc = 1'b0;
         end
         if (!m_sticky) md_ready = 1'b0;
      end else if (m_cd > 0) begin
         m_cd--;
         if (m_cd == 0 && !m_never) begin
            md_ready  = 1'b1;
            md_result = m_res;
            md_except = m_exc;
         end
      end else if (!m_sticky) begin
         md_ready = 1'b0;
      end
   end

   always @(negedge clock) begin
      if (wb_valid) begin
         wb_cyc = cyc;
         if (sb.size() == 0) begin
            chk("wb_unexpected", 32'(wb_valid), 0);
         end else begin
            e_mon = sb.pop_front();
            chk("wb_rd", 32'(wb_rd), 32'(e_mon.rd));
            chk("wb_data", wb_data, e_mon.data);
            chk("wb_except", 32'(wb_except), 32'(e_mon.exc));
            chk("timeout", 32'(timeout), 32'(e_mon.to));
         end
      end
      if (md_ctrl_mult || md_ctrl_div) begin
         pulse_cnt++;
         pulse_cyc = cyc;
         pulse_div = md_ctrl_div;
         chk("ctrl_onehot", 32'(md_ctrl_mult & md_ctrl_div), 0);
      end
   end

   task automatic run_op(input logic div, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [TAG_W-1:0] rd, input int lat,
                         input logic [WIDTH-1:0] exp_data, input logic exp_exc,
                         input logic exp_to);
      exp_t e;
      bit   seen;
      m_lat  = lat;
      e.rd   = rd;
      e.data = exp_data;
      e.exc  = exp_exc;
      e.to   = exp_to;
      sb.push_back(e);
      @(negedge clock);
      req_valid  = 1'b1;
      req_is_div = div;
      req_a      = a;
      req_b      = b;
      req_rd     = rd;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (wb_valid) begin
            seen = 1'b1;
            break;
         end
         chk("stall_busy", 32'(stall), 1);
      end
      chk("wb_seen", 32'(seen), 1);
      if (seen) chk("stall_wb", 32'(stall), 0);
      req_valid = 1'b0;
      @(negedge clock);
      chk("wb_one_cycle", 32'(wb_valid), 0);
      chk("stall_idle", 32'(stall), 0);
      chk("opA_hold", md_operandA, a);
   endtask

   task automatic start_and_find_pulse(input logic div, input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] rd,
                                       input int lat);
      exp_t e;
      bit   seen;
      m_lat  = lat;
      e.rd   = rd;
      e.data = '0;
      e.exc  = 1'b0;
      e.to   = 1'b0;
      sb.push_back(e);
      @(negedge clock);
      req_valid  = 1'b1;
      req_is_div = div;
      req_a      = a;
      req_b      = b;
      req_rd     = rd;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (md_ctrl_mult || md_ctrl_div) begin
            seen = 1'b1;
            break;
         end
      end
      chk("pulse_seen", 32'(seen), 1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_stall"}, 32'(stall), 0);
      chk({tag, "_ctrl"}, 32'({md_ctrl_mult, md_ctrl_div}), 0);
      chk({tag, "_opA"}, md_operandA, 0);
      chk({tag, "_opB"}, md_operandB, 0);
      chk({tag, "_wb"}, 32'({wb_valid, wb_except, timeout}), 0);
      chk({tag, "_wb_rd"}, 32'(wb_rd), 0);
      chk({tag, "_wb_data"}, wb_data, 0);
   endtask

   initial begin
      int p0;
      repeat (3) @(negedge clock);
      chk_all_zero("rst");
      reset = 1'b0;

      // 1: multiply 7 * -6
      p0 = pulse_cnt;
      run_op(1'b0, 32'd7, -32'sd6, 5'd3, 33, -32'sd42, 1'b0, 1'b0);
      chk("t1_pulses", 32'(pulse_cnt - p0), 1);
      chk("t1_is_mult", 32'(pulse_div), 0);
      chk("t1_latency", 32'(wb_cyc - pulse_cyc), 34);

      // 2: divide by zero
      p0 = pulse_cnt;
      run_op(1'b1, 32'd100, 32'd0, 5'd5, 10, 32'd0, 1'b1, 1'b0);
      chk("t2_pulses", 32'(pulse_cnt - p0), 1);
      chk("t2_is_div", 32'(pulse_div), 1);

      // flush in IDLE alongside req_valid must not accept
      p0 = pulse_cnt;
      @(negedge clock);
      req_valid = 1'b1;
      flush     = 1'b1;
      #1;
      chk("idle_flush_stall", 32'(stall), 0);
      @(negedge clock);
      flush     = 1'b0;
      req_valid = 1'b0;
      chk("idle_flush_noacc", 32'(stall), 0);
      repeat (3) @(negedge clock);
      chk("idle_flush_pulses", 32'(pulse_cnt - p0), 0);

      // 3: flush at BUSY cnt 10, stale ready later, then 35/5
      start_and_find_pulse(1'b0, 32'd11, 32'd13, 5'd7, 20);
      repeat (11) @(negedge clock);
      chk("t3_stall_cnt10", 32'(stall), 1);
      flush     = 1'b1;
      req_valid = 1'b0;
      void'(sb.pop_back());
      #1;
      chk("t3_flush_stall", 32'(stall), 0);
      chk("t3_flush_wb", 32'(wb_valid), 0);
      @(negedge clock);
      flush = 1'b0;
      chk("t3_idle_stall", 32'(stall), 0);
      p0 = pulse_cnt;
      repeat (15) @(negedge clock);
      run_op(1'b1, 32'd35, 32'd5, 5'd8, 5, 32'd7, 1'b0, 1'b0);
      chk("t3_fresh_pulse", 32'(pulse_cnt - p0), 1);
      chk("t3_fresh_div", 32'(pulse_div), 1);

      // 4: watchdog
      m_never = 1'b1;
      run_op(1'b0, 32'd5, 32'd6, 5'd9, 5, 32'd0, 1'b1, 1'b1);
      chk("t4_latency", 32'(wb_cyc - pulse_cyc), 41);
      m_never = 1'b0;

      // 5: sticky ready across back-to-back ops
      md_result = 32'hDEAD_BEEF;
      m_sticky  = 1'b1;
      md_ready  = 1'b1;
      p0 = pulse_cnt;
      run_op(1'b0, 32'd3, 32'd4, 5'd10, 2, 32'd12, 1'b0, 1'b0);
      run_op(1'b0, 32'd9, 32'd9, 5'd11, 2, 32'd81, 1'b0, 1'b0);
      chk("t5_pulses", 32'(pulse_cnt - p0), 2);
      m_sticky = 1'b0;
      md_ready = 1'b0;

      // 6: reset at BUSY cnt 5
      start_and_find_pulse(1'b0, 32'd6, 32'd7, 5'd4, 20);
      repeat (6) @(negedge clock);
      reset     = 1'b1;
      req_valid = 1'b0;
      void'(sb.pop_back());
      @(negedge clock);
      reset = 1'b0;
      chk_all_zero("t6");
      run_op(1'b0, 32'd2, 32'd2, 5'd1, 4, 32'd4, 1'b0, 1'b0);

      repeat (30) @(negedge clock);
      chk("sb_empty", 32'(sb.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
